// File: rtl/pong_link_pkg.sv
// Shared definitions for the two-board paddle link, used by both transmitter and receiver.
// Build option PADDLE_LINK_PARITY_EN (even parity per byte) must match on both boards.
package pong_link_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } ser_state_t;

  // Frame check byte: XOR of sync, position-high and position-low bytes.
  function automatic logic [7:0] frame_checksum(input logic [7:0] b0,
                                                input logic [7:0] b1,
                                                input logic [7:0] b2);
    return b0 ^ b1 ^ b2;
  endfunction

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART serializer with valid/ready handshake, 8N1 by default.
// With PADDLE_LINK_PARITY_EN defined an even-parity bit follows the data bits.
module uart_tx_byte
  import pong_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 564
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int            TW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  ser_state_t    state_r;
  logic [TW-1:0] timer_r;
  logic [2:0]    bit_r;
  logic [7:0]    data_r;
  logic          tx_r;
  logic          bit_end_s;

  assign bit_end_s = (timer_r == T_LAST);
  // Ready in the last STOP cycle lets the next byte start with no idle gap.
  assign ready     = (state_r == IDLE) || ((state_r == STOP) && bit_end_s);
  assign tx        = tx_r;

  // Serializer FSM: timer, bit index, shift data and the registered line output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      timer_r <= '0;
      bit_r   <= 3'd0;
      data_r  <= 8'h00;
      tx_r    <= 1'b1;
    end else begin
      if ((state_r == IDLE) || bit_end_s) begin
        timer_r <= '0;
      end else begin
        timer_r <= timer_r + TW'(1);
      end

      case (state_r)
        IDLE: begin
          if (valid) begin
            data_r  <= data_in;
            tx_r    <= 1'b0;
            state_r <= START;
          end else begin
            tx_r    <= 1'b1;
          end
        end
        START: begin
          if (bit_end_s) begin
            bit_r   <= 3'd0;
            tx_r    <= data_r[0];
            state_r <= DATA;
          end
        end
        DATA: begin
          if (bit_end_s) begin
            if (bit_r == 3'd7) begin
`ifdef PADDLE_LINK_PARITY_EN
              tx_r    <= even_parity(data_r);
              state_r <= PARITY;
`else
              tx_r    <= 1'b1;
              state_r <= STOP;
`endif
            end else begin
              bit_r <= bit_r + 3'd1;
              tx_r  <= data_r[bit_r + 3'd1];
            end
          end
        end
        PARITY: begin
          if (bit_end_s) begin
            tx_r    <= 1'b1;
            state_r <= STOP;
          end
        end
        STOP: begin
          if (bit_end_s) begin
            if (valid) begin
              data_r  <= data_in;
              tx_r    <= 1'b0;
              state_r <= START;
            end else begin
              tx_r    <= 1'b1;
              state_r <= IDLE;
            end
          end
        end
        default: begin
          tx_r    <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/paddle_pos_uart_tx.sv
// Sends the local paddle y position to the peer board once per frame as a 4-byte UART frame.
// Build option PADDLE_LINK_PARITY_EN selects 8E1 bytes instead of 8N1.
module paddle_pos_uart_tx
  import pong_link_pkg::*;
#(
  parameter int CLK_HZ       = 65_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        enable,
  input  logic [10:0] y_position,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam logic [1:0] LAST_IDX = 2'(FRAME_BYTES - 1);

  logic        vsync_q_r;
  logic        busy_r;
  logic [10:0] pos_q_r;
  logic [1:0]  idx_r;
  logic [15:0] frames_r;

  logic        start_evt_s;
  logic        byte_done_s;
  logic        ser_valid_s;
  logic        ser_ready_s;
  logic [7:0]  ser_data_s;
  logic [1:0]  next_idx_s;
  logic [7:0]  byte1_s;
  logic [7:0]  byte2_s;
  logic [7:0]  chk_s;

  assign start_evt_s = vsync & ~vsync_q_r & enable & ~busy_r;
  // While a frame is in flight the serializer is only ready in its final stop cycle.
  assign byte_done_s = busy_r & ser_ready_s;
  assign next_idx_s  = idx_r + 2'd1;
  assign byte1_s     = {5'b00000, pos_q_r[10:8]};
  assign byte2_s     = pos_q_r[7:0];
  assign chk_s       = frame_checksum(SYNC_BYTE, byte1_s, byte2_s);

  // Byte mux: sync byte on the start event, then the next frame byte at each byte boundary.
  always_comb begin
    ser_valid_s = 1'b0;
    ser_data_s  = SYNC_BYTE;
    if (start_evt_s) begin
      ser_valid_s = 1'b1;
      ser_data_s  = SYNC_BYTE;
    end else if (byte_done_s && (idx_r != LAST_IDX)) begin
      ser_valid_s = 1'b1;
      case (next_idx_s)
        2'd1:    ser_data_s = byte1_s;
        2'd2:    ser_data_s = byte2_s;
        2'd3:    ser_data_s = chk_s;
        default: ser_data_s = SYNC_BYTE;
      endcase
    end else begin
      ser_valid_s = 1'b0;
      ser_data_s  = SYNC_BYTE;
    end
  end

  // Frame sequencing: vsync edge detect, position latch, byte index, busy and frame count.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q_r <= 1'b0;
      busy_r    <= 1'b0;
      pos_q_r   <= 11'd0;
      idx_r     <= 2'd0;
      frames_r  <= 16'd0;
    end else begin
      vsync_q_r <= vsync;
      if (start_evt_s) begin
        pos_q_r <= y_position;
        busy_r  <= 1'b1;
        idx_r   <= 2'd0;
      end else if (byte_done_s) begin
        if (idx_r == LAST_IDX) begin
          busy_r   <= 1'b0;
          idx_r    <= 2'd0;
          frames_r <= frames_r + 16'd1;
        end else begin
          idx_r <= next_idx_s;
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .data_in(ser_data_s),
    .valid  (ser_valid_s),
    .ready  (ser_ready_s),
    .tx     (tx)
  );

  assign busy        = busy_r;
  assign frames_sent = frames_r;

endmodule

// File: tb/tb_paddle_pos_uart_tx.sv
// Self-checking bench for paddle_pos_uart_tx with CLKS_PER_BIT=4; honours PADDLE_LINK_PARITY_EN.
`timescale 1ns/1ps
module tb_paddle_pos_uart_tx;

  localparam int CPB = 4;
`ifdef PADDLE_LINK_PARITY_EN
  localparam int BPB = 11;
`else
  localparam int BPB = 10;
`endif
  localparam int FRAME_CYC = 4 * BPB * CPB;
  localparam int RUN_CYC   = FRAME_CYC + 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync;
  logic        enable;
  logic [10:0] y_position;
  logic        tx;
  logic        busy;
  logic [15:0] frames_sent;

  int n_checks   = 0;
  int n_pass     = 0;
  int exp_frames = 0;

  logic tx_hist   [1:RUN_CYC];
  logic busy_hist [1:RUN_CYC];

  typedef struct {
    logic [10:0] y;
    logic [10:0] y_mid;
    bit          vsync_mid;
    bit          drop_en;
    logic [31:0] bytes;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  paddle_pos_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .vsync      (vsync),
    .enable     (enable),
    .y_position (y_position),
    .tx         (tx),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Raises vsync now (cycle N); records tx/busy for cycles N+1..N+RUN_CYC.
  task automatic run_frame(input logic [10:0] y, input logic [10:0] y_mid,
                           input bit vsync_mid, input bit drop_en);
    y_position = y;
    enable     = 1'b1;
    vsync      = 1'b1;
    for (int c = 1; c <= RUN_CYC; c++) begin
      @(posedge clk); #1;
      tx_hist[c]   = tx;
      busy_hist[c] = busy;
      if (c == 10) vsync = 1'b0;
      if (c == 20) y_position = y_mid;
      if (drop_en && c == 30) enable = 1'b0;
      if (vsync_mid && c == 50) vsync = 1'b1;
      if (vsync_mid && c == 60) vsync = 1'b0;
    end
    enable = 1'b1;
  endtask

  task automatic check_frame(input string tag, input logic [31:0] exp);
    int         s;
    int         frame_err = 0;
    int         busy_cnt  = 0;
    int         late_low  = 0;
    logic [7:0] got;
    logic [7:0] eb;
    check($sformatf("%s tx_low_at_N+1", tag), tx_hist[1], 32'd0);
    check($sformatf("%s busy_at_N+1", tag), busy_hist[1], 32'd1);
    for (int j = 0; j < 4; j++) begin
      s  = 1 + BPB * CPB * j;
      eb = exp[8*j +: 8];
      for (int i = 0; i < 8; i++) got[i] = tx_hist[s + CPB * (1 + i) + 1];
      check($sformatf("%s byte%0d", tag, j), got, eb);
      if (tx_hist[s + 1] !== 1'b0) frame_err++;
      if (tx_hist[s + CPB * (BPB - 1) + 1] !== 1'b1) frame_err++;
`ifdef PADDLE_LINK_PARITY_EN
      check($sformatf("%s parity%0d", tag, j), tx_hist[s + CPB * 9 + 1], ^eb);
`endif
    end
    check($sformatf("%s framing_errors", tag), frame_err, 32'd0);
    for (int c = 1; c <= RUN_CYC; c++) begin
      if (busy_hist[c] === 1'b1) busy_cnt++;
      if (c > FRAME_CYC && tx_hist[c] !== 1'b1) late_low++;
    end
    check($sformatf("%s busy_cycles", tag), busy_cnt, FRAME_CYC);
    check($sformatf("%s busy_last_cycle", tag), busy_hist[FRAME_CYC], 32'd1);
    check($sformatf("%s tx_idle_after", tag), late_low, 32'd0);
    exp_frames++;
    check($sformatf("%s frames_sent", tag), frames_sent, exp_frames);
  endtask

  initial begin
    int lows;
    int busies;
    vecs[0] = '{11'd300,  11'd300, 1'b0, 1'b0, {8'h88, 8'h2C, 8'h01, 8'hA5}};
    vecs[1] = '{11'd668,  11'd0,   1'b0, 1'b0, {8'h3B, 8'h9C, 8'h02, 8'hA5}};
    vecs[2] = '{11'd300,  11'd300, 1'b1, 1'b0, {8'h88, 8'h2C, 8'h01, 8'hA5}};
    vecs[3] = '{11'd2047, 11'd5,   1'b0, 1'b1, {8'h5D, 8'hFF, 8'h07, 8'hA5}};
    vecs[4] = '{11'd0,    11'd0,   1'b0, 1'b0, {8'hA5, 8'h00, 8'h00, 8'hA5}};
    vecs[5] = '{11'd1280, 11'd1280,1'b0, 1'b0, {8'hA0, 8'h00, 8'h05, 8'hA5}};

    rst = 1'b1; vsync = 1'b0; enable = 1'b0; y_position = 11'd0;
    idle(3);
    check("reset tx", tx, 32'd1);
    check("reset busy", busy, 32'd0);
    check("reset frames_sent", frames_sent, 32'd0);
    rst = 1'b0;
    idle(5);

    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].y, vecs[v].y_mid, vecs[v].vsync_mid, vecs[v].drop_en);
      check_frame($sformatf("vec%0d", v), vecs[v].bytes);
      idle(5);
    end

    // Link disabled: three vsync rises must not start anything.
    enable = 1'b0; lows = 0; busies = 0;
    for (int r = 0; r < 3; r++) begin
      vsync = 1'b1;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk); #1;
        if (c == 10) vsync = 1'b0;
        if (tx !== 1'b1) lows++;
        if (busy !== 1'b0) busies++;
      end
    end
    check("disabled tx_low_cycles", lows, 32'd0);
    check("disabled busy_cycles", busies, 32'd0);
    check("disabled frames_sent", frames_sent, exp_frames);
    enable = 1'b1;
    idle(5);

    // Reset in the middle of a frame; the frame is abandoned for good.
    y_position = 11'd300; vsync = 1'b1; lows = 0;
    for (int c = 1; c <= RUN_CYC; c++) begin
      @(posedge clk); #1;
      if (c == 10) vsync = 1'b0;
      if (c == 71) begin
        check("midrst tx", tx, 32'd1);
        check("midrst busy", busy, 32'd0);
        check("midrst frames_sent", frames_sent, 32'd0);
        rst = 1'b0;
        exp_frames = 0;
      end
      if (c == 70) rst = 1'b1;
      if (c > 71 && tx !== 1'b1) lows++;
    end
    check("midrst no_resume", lows, 32'd0);
    idle(5);
    run_frame(11'd668, 11'd668, 1'b0, 1'b0);
    check_frame("after_rst", {8'h3B, 8'h9C, 8'h02, 8'hA5});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
